// File: rtl/alu_flag_unit.sv
// alu_flag_unit: CPU status register fed by the ALU flag interface, with branch
// condition evaluation and a small LIFO of saved flags.
//   clk, reset          clock and synchronous active-high reset
//   alu_flags/8, single flag sources (16-bit / 8-bit ALU) and width select
//   flags_we, flags_mask masked capture of the selected ALU flags {C,V,Z,N}
//   flags_load/din      direct load of the status register
//   push, pop           save/restore flags on the LIFO
//   cond, cond_valid    condition code evaluation request
//   flags, old_carry    status register and its carry bit for the ALU
//   cond_true/done      registered evaluation result and its valid pulse
//   stack_full/empty/err LIFO status and sticky error
module alu_flag_unit #(
    parameter int STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] alu_flags,
    input  logic [3:0] alu_flags8,
    input  logic       single,
    input  logic       flags_we,
    input  logic [3:0] flags_mask,
    input  logic       flags_load,
    input  logic [3:0] flags_din,
    input  logic       push,
    input  logic       pop,
    input  logic [3:0] cond,
    input  logic       cond_valid,
    output logic [3:0] flags,
    output logic       old_carry,
    output logic       cond_true,
    output logic       cond_done,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);
    // Pointer needs one extra bit so it can represent a full stack (0..STACK_DEPTH).
    localparam int PW = $clog2(STACK_DEPTH) + 1;

    logic [3:0]    stack [STACK_DEPTH];
    logic [PW-1:0] sp;
    logic [PW-1:0] sp_m1;
    logic          push_ok;
    logic          pop_ok;
    logic [3:0]    captured;
    logic [15:0]   cond_vec;
    logic          c, v, z, n;

    assign {c, v, z, n} = flags;
    assign old_carry    = c;
    assign stack_full   = sp == PW'(STACK_DEPTH);
    assign stack_empty  = sp == '0;
    assign sp_m1        = sp - 1'b1;
    // A simultaneous push and pop is a conflict: neither takes effect.
    assign push_ok      = push & ~pop & ~stack_full;
    assign pop_ok       = pop & ~push & ~stack_empty;
    assign captured     = (flags & ~flags_mask) | ((single ? alu_flags8 : alu_flags) & flags_mask);
    // Indexed by condition code; bit 0 is "always".
    assign cond_vec     = {z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z, ~v, v,
                           ~n, n, ~c, c, ~z, z, 1'b0, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            flags     <= '0;
            sp        <= '0;
            cond_true <= 1'b0;
            cond_done <= 1'b0;
            stack_err <= 1'b0;
        end else begin
            flags     <= flags_load ? flags_din :
                         pop_ok     ? stack[sp_m1[PW-2:0]] :
                         flags_we   ? captured : flags;
            sp        <= push_ok ? sp + 1'b1 : pop_ok ? sp_m1 : sp;
            stack_err <= stack_err | (push & pop) | (push & stack_full) | (pop & stack_empty);
            cond_done <= cond_valid;
            if (cond_valid)
                cond_true <= cond_vec[cond];
        end
    end

    // Stack storage is deliberately not reset; only the pointer is.
    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            stack[sp[PW-2:0]] <= flags;
    end
endmodule

// File: tb/tb_alu_flag_unit.sv
// tb_alu_flag_unit: directed self-checking bench for alu_flag_unit.
module tb_alu_flag_unit;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] alu_flags, alu_flags8, flags_mask, flags_din, cond;
    logic       single, flags_we, flags_load, push, pop, cond_valid;
    logic [3:0] flags;
    logic       old_carry, cond_true, cond_done, stack_full, stack_empty, stack_err;
    int         checks = 0;
    int         errors = 0;

    alu_flag_unit #(.STACK_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .alu_flags(alu_flags), .alu_flags8(alu_flags8),
        .single(single), .flags_we(flags_we), .flags_mask(flags_mask),
        .flags_load(flags_load), .flags_din(flags_din), .push(push), .pop(pop),
        .cond(cond), .cond_valid(cond_valid), .flags(flags), .old_carry(old_carry),
        .cond_true(cond_true), .cond_done(cond_done), .stack_full(stack_full),
        .stack_empty(stack_empty), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    // Reference condition table, flags ordered {C,V,Z,N}.
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic c, v, z, n;
        {c, v, z, n} = f;
        case (cc)
            4'h0: return 1'b1;
            4'h1: return 1'b0;
            4'h2: return z;
            4'h3: return !z;
            4'h4: return c;
            4'h5: return !c;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return v;
            4'h9: return !v;
            4'hA: return c && !z;
            4'hB: return !c || z;
            4'hC: return n == v;
            4'hD: return n != v;
            4'hE: return !z && (n == v);
            default: return z || (n != v);
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        reset = 0; alu_flags = 0; alu_flags8 = 0; single = 0; flags_we = 0; flags_mask = 0;
        flags_load = 0; flags_din = 0; push = 0; pop = 0; cond = 0; cond_valid = 0;
    endtask

    task automatic do_reset;
        idle(); reset = 1; tick(); reset = 0;
    endtask

    task automatic load(input logic [3:0] v);
        idle(); flags_load = 1; flags_din = v; tick(); idle();
    endtask

    task automatic do_push;
        idle(); push = 1; tick(); idle();
    endtask

    task automatic do_pop;
        idle(); pop = 1; tick(); idle();
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", flags); end
        checks++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin errors++; $display("FAIL reset_stack empty=%b full=%b exp 1/0", stack_empty, stack_full); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", stack_err); end
        checks++; if (cond_done !== 1'b0 || cond_true !== 1'b0) begin errors++; $display("FAIL reset_cond done=%b true=%b exp 0/0", cond_done, cond_true); end
        checks++; if (old_carry !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", old_carry); end
    endtask

    task automatic test_capture;
        do_reset();
        alu_flags = 4'b1010; alu_flags8 = 4'b0101; flags_mask = 4'b1111; flags_we = 1; single = 0;
        tick();
        checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL cap16 got=%b exp=1010", flags); end
        checks++; if (old_carry !== 1'b1) begin errors++; $display("FAIL cap16_carry got=%b exp=1", old_carry); end
        single = 1; tick();
        checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL cap8 got=%b exp=0101", flags); end
        checks++; if (old_carry !== 1'b0) begin errors++; $display("FAIL cap8_carry got=%b exp=0", old_carry); end
        // Mask selects only Z, which is already 0: nothing changes.
        flags_mask = 4'b0010; alu_flags8 = 4'b0000; tick();
        checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL mask_z got=%b exp=0101", flags); end
        // Mask selects only V: clears V, other bits hold.
        flags_mask = 4'b0100; tick();
        checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL mask_v got=%b exp=0001", flags); end
        flags_we = 0; alu_flags8 = 4'b1111; flags_mask = 4'b1111; tick();
        checks++; if (flags !== 4'b0001) begin errors++; $display("FAIL we_off got=%b exp=0001", flags); end
        idle();
    endtask

    task automatic test_stack;
        logic [3:0] exp_pop [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load(4'b0001 << i);
            do_push();
        end
        checks++; if (stack_full !== 1'b1 || stack_empty !== 1'b0) begin errors++; $display("FAIL stk_full full=%b empty=%b exp 1/0", stack_full, stack_empty); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL stk_noerr got=%b exp=0", stack_err); end
        do_push();
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL stk_overflow_err got=%b exp=1", stack_err); end
        checks++; if (flags !== 4'b1000 || stack_full !== 1'b1) begin errors++; $display("FAIL stk_overflow_hold flags=%b full=%b exp 1000/1", flags, stack_full); end
        for (int i = 0; i < 4; i++) begin
            do_pop();
            checks++; if (flags !== exp_pop[i]) begin errors++; $display("FAIL stk_pop%0d got=%b exp=%b", i, flags, exp_pop[i]); end
        end
        checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL stk_empty got=%b exp=1", stack_empty); end
        do_pop();
        checks++; if (flags !== 4'b0001 || stack_empty !== 1'b1) begin errors++; $display("FAIL stk_underflow flags=%b empty=%b exp 0001/1", flags, stack_empty); end
        // Error is sticky; reset is the only way out.
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL stk_err_sticky got=%b exp=1", stack_err); end
    endtask

    task automatic test_conditions;
        logic [3:0] f [4] = '{4'b1000, 4'b1010, 4'b0001, 4'b0011};
        logic [3:0] cc [4] = '{4'hA, 4'hA, 4'hD, 4'hF};
        logic       ex [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load(f[i]);
            cond = cc[i]; cond_valid = 1; tick(); idle();
            checks++; if (cond_done !== 1'b1 || cond_true !== ex[i]) begin errors++; $display("FAIL cond_dir%0d done=%b true=%b exp 1/%b", i, cond_done, cond_true, ex[i]); end
            tick();
            checks++; if (cond_done !== 1'b0 || cond_true !== ex[i]) begin errors++; $display("FAIL cond_hold%0d done=%b true=%b exp 0/%b", i, cond_done, cond_true, ex[i]); end
        end
        // Evaluation uses pre-edge flags even when a load lands on the same edge.
        load(4'b0000);
        flags_load = 1; flags_din = 4'b0010; cond = 4'h2; cond_valid = 1; tick(); idle();
        checks++; if (cond_true !== 1'b0 || flags !== 4'b0010) begin errors++; $display("FAIL cond_preedge true=%b flags=%b exp 0/0010", cond_true, flags); end
        // Full sweep, back-to-back requests every cycle.
        for (int fv = 0; fv < 16; fv++) begin
            load(4'(fv));
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c); cond_valid = 1; tick();
                e = ref_cond(4'(c), 4'(fv));
                checks++; if (cond_done !== 1'b1 || cond_true !== e) begin errors++; $display("FAIL sweep f=%b c=%h done=%b true=%b exp 1/%b", 4'(fv), 4'(c), cond_done, cond_true, e); end
            end
            idle();
        end
    endtask

    task automatic test_conflicts;
        do_reset();
        load(4'b0011);
        push = 1; flags_we = 1; alu_flags = 4'b1100; flags_mask = 4'b1111; tick(); idle();
        checks++; if (flags !== 4'b1100) begin errors++; $display("FAIL push_we got=%b exp=1100", flags); end
        do_pop();
        checks++; if (flags !== 4'b0011 || stack_empty !== 1'b1) begin errors++; $display("FAIL push_we_pop flags=%b empty=%b exp 0011/1", flags, stack_empty); end
        load(4'b0110);
        do_push();
        load(4'b0000);
        push = 1; pop = 1; tick(); idle();
        checks++; if (stack_err !== 1'b1 || flags !== 4'b0000 || stack_empty !== 1'b0) begin errors++; $display("FAIL push_pop err=%b flags=%b empty=%b exp 1/0000/0", stack_err, flags, stack_empty); end
        do_pop();
        checks++; if (flags !== 4'b0110 || stack_empty !== 1'b1) begin errors++; $display("FAIL push_pop_ptr flags=%b empty=%b exp 0110/1", flags, stack_empty); end
        do_push();
        flags_load = 1; flags_din = 4'b1111; pop = 1; tick(); idle();
        checks++; if (flags !== 4'b1111 || stack_empty !== 1'b1) begin errors++; $display("FAIL load_pop flags=%b empty=%b exp 1111/1", flags, stack_empty); end
        // Pop on empty falls through to the masked capture.
        pop = 1; flags_we = 1; alu_flags = 4'b0101; flags_mask = 4'b1111; tick(); idle();
        checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL pop_empty_we got=%b exp=0101", flags); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        load(4'b1001); do_push();
        load(4'b0110); do_push();
        reset = 1; cond_valid = 1; cond = 4'h0; push = 1; tick(); idle();
        checks++; if (cond_done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", cond_done); end
        checks++; if (stack_empty !== 1'b1 || flags !== 4'b0000 || stack_err !== 1'b0) begin errors++; $display("FAIL mid_state empty=%b flags=%b err=%b exp 1/0000/0", stack_empty, flags, stack_err); end
        tick();
        checks++; if (cond_done !== 1'b0 || stack_empty !== 1'b1) begin errors++; $display("FAIL mid_after done=%b empty=%b exp 0/1", cond_done, stack_empty); end
    endtask

    initial begin
        idle();
        test_reset();
        test_capture();
        test_stack();
        test_conditions();
        test_conflicts();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
